// File: rtl/sram_arb2_if.sv
// One requester port of the two-port SRAM arbiter: req/ack handshake with a pipelined read return.
interface sram_arb2_if #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned BYTES      = 2
);
  localparam int unsigned DW = 8 * BYTES;

  logic                  req;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [BYTES-1:0]      be;
  logic [DW-1:0]         din;
  logic                  ack;
  logic [DW-1:0]         dout;
  logic                  rvalid;

  modport master (
    output req, wr, addr, be, din,
    input  ack, dout, rvalid
  );

  modport slave (
    input  req, wr, addr, be, din,
    output ack, dout, rvalid
  );
endinterface

// File: rtl/sram_arb2.sv
// Byte-lane SRAM shared by CPU (port a) and DMA (port b) through a round-robin arbiter.
// Define SRAM_ARB_OUTREG_EN to add a read output register (read latency 2 instead of 1).
module sram_arb2 #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned BYTES      = 2,
  parameter              INIT_FILE  = "zero.mif"
) (
  input  logic       clk,
  input  logic       reset_n,
  sram_arb2_if.slave a,
  sram_arb2_if.slave b
);
  localparam int unsigned DW    = 8 * BYTES;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {GRANT_A, GRANT_B} grant_e;

  grant_e                r_last_grant;
  logic                  w_a_ack;
  logic                  w_b_ack;
  logic                  w_grant;
  logic                  w_wr;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [BYTES-1:0]      w_be;
  logic [DW-1:0]         w_din;
  logic [DW-1:0]         w_mask;
  logic                  w_a_rd;
  logic                  w_b_rd;

  (* ram_init_file = INIT_FILE *) logic [DW-1:0] r_mem [DEPTH];

  logic          r_a_vld;
  logic [DW-1:0] r_a_data;
  logic          r_b_vld;
  logic [DW-1:0] r_b_data;

  // Acks are gated by reset_n so they drop immediately on async reset.
  always_comb begin
    w_a_ack = reset_n & a.req & (~b.req | (r_last_grant == GRANT_B));
    w_b_ack = reset_n & b.req & (~a.req | (r_last_grant == GRANT_A));
    w_grant = w_a_ack | w_b_ack;
    w_wr    = w_b_ack ? b.wr   : a.wr;
    w_addr  = w_b_ack ? b.addr : a.addr;
    w_be    = w_b_ack ? b.be   : a.be;
    w_din   = w_b_ack ? b.din  : a.din;
    w_a_rd  = w_a_ack & ~a.wr;
    w_b_rd  = w_b_ack & ~b.wr;
  end

  assign a.ack = w_a_ack;
  assign b.ack = w_b_ack;

  for (genvar g = 0; g < BYTES; g++) begin : g_lane
    assign w_mask[8*g +: 8] = {8{w_be[g]}};
  end

  always_ff @(posedge clk) begin
    if (w_grant && w_wr)
      r_mem[w_addr] <= (r_mem[w_addr] & ~w_mask) | (w_din & w_mask);
  end

`ifdef SRAM_ARB_OUTREG_EN
  logic          r_a_rvalid;
  logic [DW-1:0] r_a_dout;
  logic          r_b_rvalid;
  logic [DW-1:0] r_b_dout;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= GRANT_B;
      r_a_vld      <= 1'b0;
      r_a_data     <= '0;
      r_b_vld      <= 1'b0;
      r_b_data     <= '0;
`ifdef SRAM_ARB_OUTREG_EN
      r_a_rvalid   <= 1'b0;
      r_a_dout     <= '0;
      r_b_rvalid   <= 1'b0;
      r_b_dout     <= '0;
`endif
    end else begin
      if (w_a_ack)
        r_last_grant <= GRANT_A;
      else if (w_b_ack)
        r_last_grant <= GRANT_B;

      r_a_vld <= w_a_rd;
      r_b_vld <= w_b_rd;
      if (w_a_rd)
        r_a_data <= r_mem[w_addr];
      if (w_b_rd)
        r_b_data <= r_mem[w_addr];
`ifdef SRAM_ARB_OUTREG_EN
      r_a_rvalid <= r_a_vld;
      r_b_rvalid <= r_b_vld;
      if (r_a_vld)
        r_a_dout <= r_a_data;
      if (r_b_vld)
        r_b_dout <= r_b_data;
`endif
    end
  end

`ifdef SRAM_ARB_OUTREG_EN
  assign a.rvalid = r_a_rvalid;
  assign a.dout   = r_a_dout;
  assign b.rvalid = r_b_rvalid;
  assign b.dout   = r_b_dout;
`else
  assign a.rvalid = r_a_vld;
  assign a.dout   = r_a_data;
  assign b.rvalid = r_b_vld;
  assign b.dout   = r_b_data;
`endif
endmodule

// File: tb/tb_sram_arb2.sv
// Directed, table-driven bench for sram_arb2 (both read-latency builds).
module tb_sram_arb2;
`ifdef SRAM_ARB_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sram_arb2_if #(.ADDR_WIDTH(15), .BYTES(2)) a_if ();
  sram_arb2_if #(.ADDR_WIDTH(15), .BYTES(2)) b_if ();

  sram_arb2 #(.ADDR_WIDTH(15), .BYTES(2), .INIT_FILE("zero.mif")) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .a      (a_if),
    .b      (b_if)
  );

  typedef struct {
    logic        a_req, a_wr;
    logic [14:0] a_addr;
    logic [1:0]  a_be;
    logic [15:0] a_din;
    logic        b_req, b_wr;
    logic [14:0] b_addr;
    logic [1:0]  b_be;
    logic [15:0] b_din;
    logic        e_a_ack, e_b_ack;
    logic [15:0] e_rdata;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic ar, input logic aw, input logic [14:0] aa,
                              input logic [1:0] abe, input logic [15:0] ad,
                              input logic br, input logic bw, input logic [14:0] ba,
                              input logic [1:0] bbe, input logic [15:0] bd,
                              input logic ea, input logic eb, input logic [15:0] rd);
    vec_t v;
    v.a_req = ar; v.a_wr = aw; v.a_addr = aa; v.a_be = abe; v.a_din = ad;
    v.b_req = br; v.b_wr = bw; v.b_addr = ba; v.b_be = bbe; v.b_din = bd;
    v.e_a_ack = ea; v.e_b_ack = eb; v.e_rdata = rd;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    a_if.req = v.a_req; a_if.wr = v.a_wr; a_if.addr = v.a_addr; a_if.be = v.a_be; a_if.din = v.a_din;
    b_if.req = v.b_req; b_if.wr = v.b_wr; b_if.addr = v.b_addr; b_if.be = v.b_be; b_if.din = v.b_din;
  endtask

  task automatic drive_idle();
    drive(mk(0,0,15'h0,2'b00,16'h0, 0,0,15'h0,2'b00,16'h0, 0,0,16'h0));
  endtask

  localparam int NV = 21;
  vec_t v [NV];

  initial begin
    logic [15:0] exp_a_dout;
    logic [15:0] exp_b_dout;
    int a_pulses;
    int b_pulses;
    logic [5:0] a_ack_hist;
    logic [5:0] b_ack_hist;

    //            A: req wr addr      be     din       B: req wr addr      be     din        ackA ackB rdata
    v[0]  = mk(1,1,15'h0010,2'b11,16'h1234, 0,0,15'h0000,2'b00,16'h0000, 1,0,16'h0000);
    v[1]  = mk(1,0,15'h0010,2'b00,16'h0000, 0,0,15'h0000,2'b00,16'h0000, 1,0,16'h1234);
    v[2]  = mk(0,0,15'h0000,2'b00,16'h0000, 0,0,15'h0000,2'b00,16'h0000, 0,0,16'h0000);
    v[3]  = mk(1,1,15'h0020,2'b11,16'hAABB, 0,0,15'h0000,2'b00,16'h0000, 1,0,16'h0000);
    v[4]  = mk(1,1,15'h0020,2'b01,16'h55CC, 0,0,15'h0000,2'b00,16'h0000, 1,0,16'h0000);
    v[5]  = mk(1,0,15'h0020,2'b11,16'h0000, 0,0,15'h0000,2'b00,16'h0000, 1,0,16'hAACC);
    v[6]  = mk(1,0,15'h0010,2'b00,16'h0000, 1,0,15'h0020,2'b00,16'h0000, 0,1,16'hAACC);
    v[7]  = mk(1,0,15'h0010,2'b00,16'h0000, 0,0,15'h0000,2'b00,16'h0000, 1,0,16'h1234);
    v[8]  = mk(0,0,15'h0000,2'b00,16'h0000, 1,1,15'h7FFF,2'b11,16'h0F0F, 0,1,16'h0000);
    v[9]  = mk(1,0,15'h7FFF,2'b00,16'h0000, 0,0,15'h0000,2'b00,16'h0000, 1,0,16'h0F0F);
    v[10] = mk(1,1,15'h7FFF,2'b00,16'hFFFF, 0,0,15'h0000,2'b00,16'h0000, 1,0,16'h0000);
    v[11] = mk(0,0,15'h0000,2'b00,16'h0000, 1,0,15'h7FFF,2'b00,16'h0000, 0,1,16'h0F0F);
    v[12] = mk(1,1,15'h0030,2'b11,16'h1111, 1,1,15'h0030,2'b11,16'h2222, 1,0,16'h0000);
    v[13] = mk(0,0,15'h0000,2'b00,16'h0000, 1,1,15'h0030,2'b11,16'h2222, 0,1,16'h0000);
    v[14] = mk(1,0,15'h0030,2'b00,16'h0000, 0,0,15'h0000,2'b00,16'h0000, 1,0,16'h2222);
    v[15] = mk(1,1,15'h0040,2'b11,16'h4444, 0,0,15'h0000,2'b00,16'h0000, 1,0,16'h0000);
    v[16] = mk(1,1,15'h0040,2'b11,16'h9999, 1,0,15'h0010,2'b00,16'h0000, 0,1,16'h1234);
    v[17] = mk(0,0,15'h0000,2'b00,16'h0000, 0,0,15'h0000,2'b00,16'h0000, 0,0,16'h0000);
    v[18] = mk(1,0,15'h0040,2'b00,16'h0000, 0,0,15'h0000,2'b00,16'h0000, 1,0,16'h4444);
    v[19] = mk(0,0,15'h0000,2'b00,16'h0000, 0,0,15'h0000,2'b00,16'h0000, 0,0,16'h0000);
    v[20] = mk(0,0,15'h0000,2'b00,16'h0000, 0,0,15'h0000,2'b00,16'h0000, 0,0,16'h0000);

    // Reset: requests held high must still see no ack.
    drive_idle();
    a_if.req = 1'b1;
    b_if.req = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_a_ack", a_if.ack, 0);
    chk("rst_b_ack", b_if.ack, 0);
    chk("rst_a_rvalid", a_if.rvalid, 0);
    chk("rst_b_rvalid", b_if.rvalid, 0);
    chk("rst_a_dout", a_if.dout, 0);
    chk("rst_b_dout", b_if.dout, 0);
    drive_idle();
    reset_n = 1'b1;

    exp_a_dout = '0;
    exp_b_dout = '0;
    for (int r = 0; r < NV; r++) begin
      logic ea_rv;
      logic eb_rv;
      @(negedge clk);
      drive(v[r]);
      #1;
      ea_rv = 1'b0;
      eb_rv = 1'b0;
      if (r >= LAT) begin
        ea_rv = v[r-LAT].e_a_ack & ~v[r-LAT].a_wr;
        eb_rv = v[r-LAT].e_b_ack & ~v[r-LAT].b_wr;
        if (ea_rv) exp_a_dout = v[r-LAT].e_rdata;
        if (eb_rv) exp_b_dout = v[r-LAT].e_rdata;
      end
      chk($sformatf("v%0d_a_ack", r), a_if.ack, v[r].e_a_ack);
      chk($sformatf("v%0d_b_ack", r), b_if.ack, v[r].e_b_ack);
      chk($sformatf("v%0d_a_rvalid", r), a_if.rvalid, ea_rv);
      chk($sformatf("v%0d_b_rvalid", r), b_if.rvalid, eb_rv);
      chk($sformatf("v%0d_a_dout", r), a_if.dout, exp_a_dout);
      chk($sformatf("v%0d_b_dout", r), b_if.dout, exp_b_dout);
    end
    @(negedge clk);
    drive_idle();

    // Contention from reset: both ports read for 6 cycles; expect A,B,A,B,A,B.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    a_pulses = 0;
    b_pulses = 0;
    a_ack_hist = '0;
    b_ack_hist = '0;
    for (int k = 0; k < 6 + LAT; k++) begin
      @(negedge clk);
      if (k < 6) begin
        a_if.req = 1'b1; a_if.wr = 1'b0; a_if.addr = 15'h0010;
        b_if.req = 1'b1; b_if.wr = 1'b0; b_if.addr = 15'h0020;
      end else begin
        drive_idle();
      end
      #1;
      if (k < 6) begin
        chk($sformatf("cont%0d_a_ack", k), a_if.ack, (k % 2 == 0));
        chk($sformatf("cont%0d_b_ack", k), b_if.ack, (k % 2 == 1));
        a_ack_hist[k] = a_if.ack;
        b_ack_hist[k] = b_if.ack;
      end
      if (k >= LAT) begin
        chk($sformatf("cont%0d_a_rvalid", k), a_if.rvalid, ((k - LAT) % 2 == 0));
        chk($sformatf("cont%0d_b_rvalid", k), b_if.rvalid, ((k - LAT) % 2 == 1));
      end
      if (a_if.rvalid) begin
        a_pulses++;
        chk($sformatf("cont%0d_a_dout", k), a_if.dout, 16'h1234);
      end
      if (b_if.rvalid) begin
        b_pulses++;
        chk($sformatf("cont%0d_b_dout", k), b_if.dout, 16'hAACC);
      end
    end
    chk("cont_a_pulses", a_pulses, 3);
    chk("cont_b_pulses", b_pulses, 3);
    chk("cont_ack_disjoint", a_ack_hist & b_ack_hist, 0);

    // Reset mid-read: reset drops in the cycle after A's read ack.
    @(negedge clk);
    a_if.req = 1'b1; a_if.wr = 1'b0; a_if.addr = 15'h0010;
    #1;
    chk("mid_a_ack", a_if.ack, 1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("mid%0d_a_rvalid", k), a_if.rvalid, 0);
      chk($sformatf("mid%0d_a_dout", k), a_if.dout, 0);
      chk($sformatf("mid%0d_a_ack", k), a_if.ack, 0);
    end
    b_if.req = 1'b1; b_if.wr = 1'b0; b_if.addr = 15'h0020;
    reset_n = 1'b1;
    #1;
    chk("post_rst_a_ack", a_if.ack, 1);
    chk("post_rst_b_ack", b_if.ack, 0);
    @(negedge clk);
    #1;
    chk("post_rst2_a_ack", a_if.ack, 0);
    chk("post_rst2_b_ack", b_if.ack, 1);
    @(negedge clk);
    drive_idle();
    repeat (LAT + 1) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
